// File: rtl/mfp_ahb_sevenseg.sv
// mfp_ahb_sevenseg: AHB-Lite slave that scans eight seven-segment digits.
// Define MFP_SEVENSEG_DIMMING_EN to add the BRIGHT register at offset 0x10.
module mfp_ahb_sevenseg #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [4:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [7:0]  disenout,
  output logic [7:0]  disout
);

  localparam logic [CNT_W-1:0] LP_LAST =
    CNT_W'(REFRESH_DIV - 1);

  logic             r_wr_pend;
  logic [2:0]       r_wr_addr;
  logic [7:0]       r_en;
  logic [7:0]       r_dp;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_hrdata;
  logic [CNT_W-1:0] r_pre;
  logic [2:0]       r_idx;
  logic [7:0]       r_an;
  logic [7:0]       r_seg;
`ifdef MFP_SEVENSEG_DIMMING_EN
  logic [3:0]       r_br;
`endif

  logic             w_acc;
  logic             w_fwd;
  logic             w_lit;
  logic [31:0]      w_rd_reg;
  logic [31:0]      w_rdata;
  logic [31:0]      w_wdata;
  logic [4:0]       w_code;
  logic [7:0]       w_onehot;
  logic             w_unused;

  function automatic logic [31:0] f_fmt(
    input logic [2:0]  a,
    input logic [31:0] d
  );
    logic [31:0] v;
    v = '0;
    case (a)
      3'd0, 3'd3: v = {24'h0, d[7:0]};
      3'd1, 3'd2: v = d & 32'h1F1F_1F1F;
`ifdef MFP_SEVENSEG_DIMMING_EN
      3'd4:       v = {28'h0, d[3:0]};
`endif
      default:    v = '0;
    endcase
    return v;
  endfunction

  // Active-low segments, bit6 = a ... bit0 = g
  function automatic logic [6:0] f_glyph(
    input logic [4:0] c
  );
    logic [6:0] g;
    g = 7'b1111111;
    case (c)
      5'h00: g = 7'b0000001;
      5'h01: g = 7'b1001111;
      5'h02: g = 7'b0010010;
      5'h03: g = 7'b0000110;
      5'h04: g = 7'b1001100;
      5'h05: g = 7'b0100100;
      5'h06: g = 7'b0100000;
      5'h07: g = 7'b0001111;
      5'h08: g = 7'b0000000;
      5'h09: g = 7'b0000100;
      5'h0A: g = 7'b0001000;
      5'h0B: g = 7'b1100000;
      5'h0C: g = 7'b0110001;
      5'h0D: g = 7'b1000010;
      5'h0E: g = 7'b0110000;
      5'h0F: g = 7'b0111000;
      5'h11: g = 7'b1111110;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  assign w_acc    = HSEL & HREADY & HTRANS[1];
  assign w_unused = ^{HSIZE, HTRANS[0], HADDR[1:0]};

  always_comb begin
    w_rd_reg = '0;
    case (HADDR[4:2])
      3'd0: w_rd_reg = {24'h0, r_en};
      3'd1: w_rd_reg = r_hi;
      3'd2: w_rd_reg = r_lo;
      3'd3: w_rd_reg = {24'h0, r_dp};
`ifdef MFP_SEVENSEG_DIMMING_EN
      3'd4: w_rd_reg = {28'h0, r_br};
`endif
      default: w_rd_reg = '0;
    endcase
  end

  // A read overlapping the data phase of a write to it sees HWDATA
  assign w_fwd   = r_wr_pend && (r_wr_addr == HADDR[4:2]);
  assign w_rdata = w_fwd ? f_fmt(HADDR[4:2], HWDATA) : w_rd_reg;
  assign w_wdata = f_fmt(r_wr_addr, HWDATA);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr_pend <= 1'b0;
      r_wr_addr <= '0;
      r_hrdata  <= '0;
    end else begin
      r_wr_pend <= w_acc & HWRITE;
      if (w_acc)
        r_wr_addr <= HADDR[4:2];
      if (w_acc && !HWRITE)
        r_hrdata <= w_rdata;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_en <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_dp <= '0;
`ifdef MFP_SEVENSEG_DIMMING_EN
      r_br <= 4'hF;
`endif
    end else if (r_wr_pend) begin
      case (r_wr_addr)
        3'd0: r_en <= w_wdata[7:0];
        3'd1: r_hi <= w_wdata;
        3'd2: r_lo <= w_wdata;
        3'd3: r_dp <= w_wdata[7:0];
`ifdef MFP_SEVENSEG_DIMMING_EN
        3'd4: r_br <= w_wdata[3:0];
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == LP_LAST) begin
      r_pre <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

`ifdef MFP_SEVENSEG_DIMMING_EN
  localparam logic [CNT_W+3:0] LP_ONE  = 1;
  localparam logic [CNT_W+3:0] LP_DIVW =
    (CNT_W+4)'(REFRESH_DIV);

  logic [CNT_W+3:0] w_bp1;
  logic [CNT_W+3:0] w_prod;
  logic [CNT_W+3:0] w_thr;

  // On-time is (BRIGHT+1)/16 of the slot
  assign w_bp1  = {{CNT_W{1'b0}}, r_br} + LP_ONE;
  assign w_prod = w_bp1 * LP_DIVW;
  assign w_thr  = w_prod >> 4;
  assign w_lit  = ({4'b0000, r_pre} < w_thr);
`else
  assign w_lit  = 1'b1;
`endif

  assign w_code   = r_idx[2] ?
                    r_hi[{r_idx[1:0], 3'b000} +: 5] :
                    r_lo[{r_idx[1:0], 3'b000} +: 5];
  assign w_onehot = 8'b0000_0001 << r_idx;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_an  <= 8'hFF;
      r_seg <= 8'hFF;
    end else begin
      r_an  <= (w_lit && r_en[r_idx]) ? ~w_onehot : 8'hFF;
      r_seg <= {~r_dp[r_idx], f_glyph(w_code)};
    end
  end

  assign HRDATA    = r_hrdata;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign disenout  = r_an;
  assign disout    = r_seg;

endmodule

// File: tb/tb_mfp_ahb_sevenseg.sv
// tb_mfp_ahb_sevenseg: random AHB traffic against a register/scan model.
// Honours MFP_SEVENSEG_DIMMING_EN the same way as the design.
module tb_mfp_ahb_sevenseg;

  localparam int DIV = 4;
`ifdef MFP_SEVENSEG_DIMMING_EN
  localparam bit DIM = 1'b1;
`else
  localparam bit DIM = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [4:0]  HADDR = '0;
  logic [1:0]  HTRANS = '0;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'b010;
  logic        HREADY = 1'b1;
  logic [31:0] HWDATA = '0;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [7:0]  disenout;
  logic [7:0]  disout;

  always #5 HCLK = ~HCLK;

  mfp_ahb_sevenseg #(
    .REFRESH_DIV (DIV),
    .CNT_W       (16)
  ) u_dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HREADY    (HREADY),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .disenout  (disenout),
    .disout    (disout)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  always @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) cyc <= 0;
    else          cyc <= cyc + 1;

  // Lit segments of each hex glyph
  string SEGS [16] = '{
    "abcdef", "bc", "abdeg", "abcdg",
    "bcfg", "acdfg", "acdefg", "abc",
    "abcdefg", "abcdfg", "abcefg", "cdefg",
    "adef", "bcdeg", "adefg", "aefg"
  };

  logic [31:0] m_reg [8];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [4:0] c);
    logic [6:0] g;
    int k;
    g = 7'h7F;
    if (c == 5'h11) g = 7'h7E;
    else if (c < 5'h10)
      for (int j = 0; j < SEGS[c[3:0]].len(); j++) begin
        k = int'(SEGS[c[3:0]][j]) - 97;
        g[6 - k] = 1'b0;
      end
    return g;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    if (DIM) m_reg[4] = 32'd15;
  endtask

  task automatic m_write(input logic [2:0] a, input logic [31:0] d);
    case (a)
      3'd0, 3'd3: m_reg[a] = {24'h0, d[7:0]};
      3'd1, 3'd2: begin
        m_reg[a] = '0;
        for (int k = 0; k < 4; k++) m_reg[a][8*k +: 5] = d[8*k +: 5];
      end
      3'd4: if (DIM) m_reg[4] = {28'h0, d[3:0]};
      default: ;
    endcase
  endtask

  task automatic bus_idle();
    HSEL = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HADDR = '0;
    HREADY = 1'b1;
  endtask

  task automatic ahb_write(input logic [2:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1;
    HADDR = {a, 2'b00}; HSIZE = 3'($urandom_range(0, 2));
    @(posedge HCLK); #1;
    bus_idle();
    HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [2:0] a, output logic [31:0] rd);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0;
    HADDR = {a, 2'b00}; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    bus_idle();
    rd = HRDATA;
  endtask

  task automatic ahb_wr_rd(input logic [2:0] wa, input logic [31:0] wd,
                           input logic [2:0] ra, output logic [31:0] rd);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1;
    HADDR = {wa, 2'b00}; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    HWDATA = wd;
    HWRITE = 1'b0;
    HADDR = {ra, 2'b00};
    @(posedge HCLK); #1;
    bus_idle();
    rd = HRDATA;
  endtask

  task automatic ahb_ignored(input int kind, input logic [2:0] a,
                             input logic [31:0] d);
    HWRITE = 1'b1;
    HADDR = {a, 2'b00};
    case (kind)
      0: begin HSEL = 1'b1; HTRANS = 2'b00; end
      1: begin HSEL = 1'b1; HTRANS = 2'b01; end
      2: begin HSEL = 1'b0; HTRANS = 2'b10; end
      default: begin HSEL = 1'b1; HTRANS = 2'b10; HREADY = 1'b0; end
    endcase
    @(posedge HCLK); #1;
    bus_idle();
    HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  // Expected pins from cycles elapsed since reset release
  task automatic scan_check(input int n);
    int e, idx, pre, thr;
    logic [4:0] code;
    logic [7:0] xan, xseg;
    @(posedge HCLK);
    repeat (n) begin
      @(negedge HCLK);
      e = cyc - 1;
      idx = (e / DIV) % 8;
      pre = e % DIV;
      code = (idx < 4) ? m_reg[2][8*idx +: 5] : m_reg[1][8*(idx-4) +: 5];
      thr = DIM ? ((int'(m_reg[4][3:0]) + 1) * DIV) / 16 : DIV;
      xan = 8'hFF;
      if (m_reg[0][idx] && pre < thr) xan[idx] = 1'b0;
      xseg = {~m_reg[3][idx], glyph(code)};
      chk("disenout", {24'h0, disenout}, {24'h0, xan});
      chk("disout", {24'h0, disout}, {24'h0, xseg});
      chk("hreadyout", {31'h0, HREADYOUT}, 32'd1);
      chk("hresp", {31'h0, HRESP}, 32'd0);
    end
    @(posedge HCLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] d;
    logic [2:0]  a, b;

    m_reset();
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_disenout", {24'h0, disenout}, 32'hFF);
    chk("rst_disout", {24'h0, disout}, 32'hFF);
    chk("rst_hrdata", HRDATA, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    for (int i = 0; i < 8; i++) begin
      ahb_read(3'(i), rd);
      chk("rst_reg", rd, m_reg[i]);
    end

    ahb_write(3'd0, 32'h0000_0001); m_write(3'd0, 32'h0000_0001);
    ahb_write(3'd2, 32'h0000_0003); m_write(3'd2, 32'h0000_0003);
    ahb_write(3'd3, 32'h0000_0001); m_write(3'd3, 32'h0000_0001);
    scan_check(36);

    ahb_write(3'd0, 32'h0000_00FF); m_write(3'd0, 32'h0000_00FF);
    ahb_write(3'd2, 32'h0302_0100); m_write(3'd2, 32'h0302_0100);
    ahb_write(3'd1, 32'h1110_0F08); m_write(3'd1, 32'h1110_0F08);
    scan_check(36);

    ahb_wr_rd(3'd0, 32'h0000_00A5, 3'd0, rd);
    m_write(3'd0, 32'h0000_00A5);
    chk("fwd_en", rd, 32'h0000_00A5);
    ahb_read(3'd5, rd);
    chk("rd_0x14", rd, 32'h0);

    ahb_write(3'd4, 32'h0000_0003); m_write(3'd4, 32'h0000_0003);
    ahb_read(3'd4, rd);
    chk("bright", rd, DIM ? 32'd3 : 32'd0);
    scan_check(36);

    for (int k = 0; k < 4; k++) begin
      d = $urandom;
      ahb_ignored(k, 3'd0, d);
      ahb_read(3'd0, rd);
      chk("ignored", rd, m_reg[0]);
    end

    for (int it = 0; it < 60; it++) begin
      a = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) a = 3'($urandom_range(0, 4));
      d = $urandom;
      case ($urandom_range(0, 3))
        0: begin
          ahb_write(a, d);
          m_write(a, d);
        end
        1: begin
          ahb_read(a, rd);
          chk("rd", rd, m_reg[a]);
        end
        2: begin
          b = ($urandom_range(0, 1) != 0) ? a : 3'($urandom_range(0, 7));
          ahb_wr_rd(a, d, b, rd);
          m_write(a, d);
          chk("wr_rd", rd, m_reg[b]);
        end
        default: begin
          ahb_ignored(int'($urandom_range(0, 3)), a, d);
          ahb_read(a, rd);
          chk("ign_rd", rd, m_reg[a]);
        end
      endcase
      if (it % 15 == 14) scan_check(34);
    end

    ahb_write(3'd0, 32'h0000_00FF); m_write(3'd0, 32'h0000_00FF);
    ahb_read(3'd0, rd);
    chk("pre_rst_rd", rd, 32'h0000_00FF);
    scan_check(10);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 5'h08;
    @(posedge HCLK); #1;
    bus_idle();
    HWDATA = 32'h0A0B_0C0D;
    #2;
    HRESETn = 1'b0;
    #1;
    chk("mid_rst_disenout", {24'h0, disenout}, 32'hFF);
    chk("mid_rst_disout", {24'h0, disout}, 32'hFF);
    chk("mid_rst_hrdata", HRDATA, 32'h0);
    m_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    ahb_read(3'd2, rd);
    chk("pend_discard", rd, 32'h0);
    ahb_read(3'd0, rd);
    chk("en_after_rst", rd, 32'h0);
    d = $urandom;
    ahb_write(3'd0, 32'h0000_00FF); m_write(3'd0, 32'h0000_00FF);
    ahb_write(3'd2, d); m_write(3'd2, d);
    scan_check(36);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
